aes_dec_key_sched: RTL and testbench

- Upstream key source for the registered AES-128 decrypt round stages.
- Accepts a 128-bit cipher key and expands it iteratively, one round key per cycle, into an 11-entry round-key store.
- Serves round keys by index through a registered read port, plus a dedicated rk10 output for the initial AddRoundKey ahead of the first decrypt round.
- Each decrypt round fetches its key by index 9 down to 0.

---
 rtl/aes_pkg.sv | 97 +++++++++
 rtl/aes_key_expand_step.sv | 33 +++
 rtl/aes_dec_key_sched.sv | 165 ++++++++++++++++
 tb/tb_aes_dec_key_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the key scheduler and round stages:
//   NR / NK          - round count and key length in 32-bit words
//   block_t          - 128-bit state / round-key type, byte 0 at [127:120]
//   ks_state_t       - key-schedule FSM states (IDLE / EXPAND / DONE)
//   RCON             - round constants, indexed by round 1..10
//   sbox()           - forward S-box lookup
//   sub_word()       - S-box applied to each byte of a 32-bit word
//   inv_mix_columns()- InvMixColumns over a full 128-bit block
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned NK = 4;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns: each column multiplied by the circulant {0e,0b,0d,09}
    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            for (int unsigned r = 0; r < 4; r++) begin
                logic [7:0] b;
                b = (r == 0) ? a0 : (r == 1) ? a1 : (r == 2) ? a2 : a3;
                x2[r] = xtime(b);
                x4[r] = xtime(x2[r]);
                x8[r] = xtime(x4[r]);
                m9[r] = x8[r] ^ b;
                mb[r] = x8[r] ^ x2[r] ^ b;
                md[r] = x8[r] ^ x4[r] ^ b;
                me[r] = x8[r] ^ x4[r] ^ x2[r];
            end
            o[127 - 32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[119 - 32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[111 - 32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[103 - 32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// ---------------------------------------------------------------------------
// aes_key_expand_step
// Combinational single round of AES-128 key expansion (four S-box lookups).
//   prev_key - previous round key {w0,w1,w2,w3}
//   rcon     - round constant byte, applied in the MSB byte of w4
//   next_key - next round key {w4,w5,w6,w7}
// ---------------------------------------------------------------------------
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w4, w5, w6, w7;
    logic [31:0] rot;

    always_comb begin
        w0  = prev_key[127:96];
        w1  = prev_key[95:64];
        w2  = prev_key[63:32];
        w3  = prev_key[31:0];
        rot = {w3[23:0], w3[31:24]};
        w4  = w0 ^ sub_word(rot) ^ {rcon, 24'h000000};
        w5  = w4 ^ w1;
        w6  = w5 ^ w2;
        w7  = w6 ^ w3;
        next_key = {w4, w5, w6, w7};
    end

endmodule

// File: rtl/aes_dec_key_sched.sv
// ---------------------------------------------------------------------------
// aes_dec_key_sched
// AES-128 decrypt-side key scheduler. Expands a cipher key one round key per
// cycle into an 11-entry store and serves keys by index.
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset
//   key_in     - cipher key, byte 0 at [127:120]
//   key_load   - one-cycle strobe, samples key_in and (re)starts expansion
//   rd_addr    - round-key index 0..10
//   rd_data    - round key rd_addr, registered, 1-cycle latency
//   rk_last    - round key 10, registered, valid while keys_valid=1
//   busy       - expansion in progress
//   keys_valid - all 11 round keys present and consistent
// Parameters:
//   ZERO_INVALID - 1: out-of-range or not-yet-valid reads return zero
//                  0: rd_addr>10 reads key 10, no validity gating
//   NR is fixed at 10 (package constant).
// Optional build macro:
//   AES_KEY_SCHED_EQUIV_INV_EN - store keys 1..9 after InvMixColumns
//   (equivalent inverse cipher); keys 0 and 10 are left unmodified.
// ---------------------------------------------------------------------------
module aes_dec_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned ZERO_INVALID = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic [127:0] rk_last,
    output logic         busy,
    output logic         keys_valid
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_t  state_q, state_d;
    logic [3:0] cnt_q;
    block_t     rk_q [0:NR];
    block_t     prev_key, next_raw, stored_key, rd_next;
    logic [7:0] rcon;
    logic       do_load, do_step, do_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_step = 1'b0;
        do_last = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (key_load) begin
                    do_load = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                // A load mid-expansion restarts from round 0 with the new key
                if (key_load) begin
                    do_load = 1'b1;
                end else begin
                    do_step = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        do_last = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rcon = 8'h00;
        if (cnt_q >= 4'd1 && cnt_q <= LAST_IDX) begin
            rcon = RCON[cnt_q];
        end
    end

    aes_key_expand_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_raw)
    );

`ifdef AES_KEY_SCHED_EQUIV_INV_EN
    // Stored keys 1..9 are transformed, so the raw key chain lives apart
    block_t chain_q;

    assign prev_key   = chain_q;
    assign stored_key = do_last ? next_raw : inv_mix_columns(next_raw);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else if (do_load) begin
            chain_q <= key_in;
        end else if (do_step) begin
            chain_q <= next_raw;
        end
    end
`else
    logic [3:0] prev_idx;

    assign prev_idx   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    assign prev_key   = rk_q[prev_idx];
    assign stored_key = next_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
            cnt_q      <= '0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            rk_last    <= '0;
        end else if (do_load) begin
            rk_q[0]    <= key_in;
            cnt_q      <= 4'd1;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
        end else if (do_step) begin
            rk_q[cnt_q] <= stored_key;
            cnt_q       <= cnt_q + 4'd1;
            if (do_last) begin
                busy       <= 1'b0;
                keys_valid <= 1'b1;
                rk_last    <= next_raw;
            end
        end
    end

    // Read uses pre-edge store contents, so a same-cycle write is not seen
    always_comb begin
        rd_next = '0;
        if (rd_addr > LAST_IDX) begin
            rd_next = (ZERO_INVALID != 0) ? '0 : rk_q[NR];
        end else if ((ZERO_INVALID != 0) && !keys_valid) begin
            rd_next = '0;
        end else begin
            rd_next = rk_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_key_sched
// Self-checking bench for aes_dec_key_sched. Reference keys come from a
// word-oriented FIPS-197 expansion whose S-box is derived from GF(2^8)
// inversion plus the affine map. Honours AES_KEY_SCHED_EQUIV_INV_EN.
// ---------------------------------------------------------------------------
module tb_aes_dec_key_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
    logic [127:0] rk_last;
    logic         busy;
    logic         keys_valid;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb   [256];
    logic [127:0] m_rk [11];

    localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPS_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_SEQ    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_SEQ_A  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_dec_key_sched #(.ZERO_INVALID(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rk_last    (rk_last),
        .busy       (busy),
        .keys_valid (keys_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] xb;
            xb  = 8'(x);
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] m_imc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8*(4*c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = gmul(8'h0e, a[r]) ^ gmul(8'h0b, a[(r+1)%4])
                                          ^ gmul(8'h0d, a[(r+2)%4]) ^ gmul(8'h09, a[(r+3)%4]);
            end
        end
        return o;
    endfunction

    // Value a consumer should see for index a once keys are valid
    function automatic logic [127:0] exp_read(input int a);
        if (a > 10) return '0;
`ifdef AES_KEY_SCHED_EQUIV_INV_EN
        if (a >= 1 && a <= 9) return m_imc(m_rk[a]);
`endif
        return m_rk[a];
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!keys_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        key_load = 1'b0;
        key_in   = '0;
        rd_addr  = 4'd0;
        #2;
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if (rk_last !== '0) begin failures++; $display("FAIL reset_rk_last got=%h exp=0", rk_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (keys_valid !== 1'b0) begin failures++; $display("FAIL reset_keys_valid got=%b exp=0", keys_valid); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fips_vector();
        int n;
        logic [127:0] e1;
        load_key(K_FIPS);
        n = 0;
        while (busy && n < 30) begin
            n++;
            tick();
        end
        checks++; if (n != 10) begin failures++; $display("FAIL fips_busy_cycles got=%0d exp=10", n); end
        checks++; if (keys_valid !== 1'b1) begin failures++; $display("FAIL fips_keys_valid got=%b exp=1", keys_valid); end
        checks++; if (rk_last !== K_FIPS_A) begin failures++; $display("FAIL fips_rk_last got=%h exp=%h", rk_last, K_FIPS_A); end
`ifdef AES_KEY_SCHED_EQUIV_INV_EN
        e1 = m_imc(K_FIPS_1);
`else
        e1 = K_FIPS_1;
`endif
        rd_addr = 4'd1;
        tick();
        checks++; if (rd_data !== e1) begin failures++; $display("FAIL fips_rd1 got=%h exp=%h", rd_data, e1); end
        rd_addr = 4'd10;
        tick();
        checks++; if (rd_data !== K_FIPS_A) begin failures++; $display("FAIL fips_rd10 got=%h exp=%h", rd_data, K_FIPS_A); end
        rd_addr = 4'd0;
        tick();
        checks++; if (rd_data !== K_FIPS) begin failures++; $display("FAIL fips_rd0 got=%h exp=%h", rd_data, K_FIPS); end
    endtask

    task automatic test_seq_vector();
        int n;
        load_key(K_SEQ);
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL seq_valid_latency got=%0d exp=10", n); end
        checks++; if (rk_last !== K_SEQ_A) begin failures++; $display("FAIL seq_rk_last got=%h exp=%h", rk_last, K_SEQ_A); end
        rd_addr = 4'd0;
        tick();
        checks++; if (rd_data !== K_SEQ) begin failures++; $display("FAIL seq_rd0 got=%h exp=%h", rd_data, K_SEQ); end
    endtask

    // key_load edge writes rk[0] while the read port samples index 0
    task automatic test_same_cycle_rw();
        int n;
        logic [127:0] k;
        k       = rand_key();
        rd_addr = 4'd0;
        load_key(k);
        checks++; if (rd_data !== K_SEQ) begin failures++; $display("FAIL rw_old_value got=%h exp=%h", rd_data, K_SEQ); end
        checks++; if (keys_valid !== 1'b0) begin failures++; $display("FAIL rw_valid_drop got=%b exp=0", keys_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rw_busy got=%b exp=1", busy); end
        wait_valid(n);
        model_expand(k);
        tick();
        checks++; if (rd_data !== k) begin failures++; $display("FAIL rw_new_rd0 got=%h exp=%h", rd_data, k); end
    endtask

    task automatic test_restart();
        int n;
        load_key(rand_key());
        tick();
        tick();
        tick();
        load_key(K_SEQ);
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL restart_valid_latency got=%0d exp=10", n); end
        checks++; if (rk_last !== K_SEQ_A) begin failures++; $display("FAIL restart_rk_last got=%h exp=%h", rk_last, K_SEQ_A); end
        model_expand(K_SEQ);
        for (int a = 0; a <= 10; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== exp_read(a)) begin
                failures++;
                $display("FAIL restart_rd%0d got=%h exp=%h", a, rd_data, exp_read(a));
            end
        end
    endtask

    task automatic test_invalid_reads();
        int n;
        logic [127:0] k;
        k = rand_key();
        load_key(k);
        rd_addr = 4'd5;
        tick();
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL inval_rd5_busy got=%h exp=0", rd_data); end
        wait_valid(n);
        model_expand(k);
        for (int a = 11; a <= 15; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== '0) begin failures++; $display("FAIL inval_rd%0d got=%h exp=0", a, rd_data); end
        end
        rd_addr = 4'd5;
        tick();
        checks++; if (rd_data !== exp_read(5)) begin failures++; $display("FAIL inval_rd5_valid got=%h exp=%h", rd_data, exp_read(5)); end
    endtask

    task automatic test_random_keys();
        int n;
        logic [127:0] k;
        for (int t = 0; t < 4; t++) begin
            k = rand_key();
            load_key(k);
            wait_valid(n);
            model_expand(k);
            checks++; if (n != 10) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=10", t, n); end
            checks++; if (rk_last !== m_rk[10]) begin failures++; $display("FAIL rand%0d_rk_last got=%h exp=%h", t, rk_last, m_rk[10]); end
            for (int i = 0; i < 16; i++) begin
                int a;
                a = int'($urandom_range(0, 15));
                rd_addr = 4'(a);
                tick();
                checks++;
                if (rd_data !== exp_read(a)) begin
                    failures++;
                    $display("FAIL rand%0d_rd%0d got=%h exp=%h", t, a, rd_data, exp_read(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int highs;
        logic [127:0] k;
        load_key(rand_key());
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL midrst_rd_data got=%h exp=0", rd_data); end
        checks++; if (rk_last !== '0) begin failures++; $display("FAIL midrst_rk_last got=%h exp=0", rk_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (keys_valid !== 1'b0) begin failures++; $display("FAIL midrst_keys_valid got=%b exp=0", keys_valid); end
        tick();
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (keys_valid !== 1'b0 || busy !== 1'b0) highs++;
        end
        checks++; if (highs != 0) begin failures++; $display("FAIL midrst_idle_after got=%0d exp=0", highs); end
        k = rand_key();
        load_key(k);
        wait_valid(n);
        model_expand(k);
        checks++; if (n != 10) begin failures++; $display("FAIL midrst_reload_latency got=%0d exp=10", n); end
        rd_addr = 4'd3;
        tick();
        checks++; if (rd_data !== exp_read(3)) begin failures++; $display("FAIL midrst_rd3 got=%h exp=%h", rd_data, exp_read(3)); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_vector();
        test_seq_vector();
        test_same_cycle_rw();
        test_restart();
        test_invalid_reads();
        test_random_keys();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
